// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
// Holds the FSM state encoding, bus widths, the latency counter width and the byte parity helpers.
// Word parity is used only when the build defines DMEM_PARITY_EN.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } dmem_state_t;

  localparam int DATA_W     = 64;
  localparam int REQ_ADDR_W = 16;
  localparam int CNT_W      = 3;

  // Even parity of one byte: the stored bit makes the 9-bit group XOR to zero.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

  // One parity bit per byte; bit i covers data[8*i +: 8].
  function automatic logic [7:0] word_parity(input logic [DATA_W-1:0] d);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      p[i] = byte_parity(d[8*i +: 8]);
    end
    return p;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous RAM, 2**ADDR_W words of WIDTH bits.
// Latency: a write lands on the enabled edge; the read word is registered on that same edge.
// Backpressure: none; the owner enables it at most once per transaction.
module dmem_array #(
  parameter int ADDR_W = 8,
  parameter int WIDTH  = 64
) (
  input  logic              clk,
  input  logic              en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  rd_data
);

  // Words start at zero so a never-written word reads back as clean data and parity.
  logic [WIDTH-1:0] mem [2**ADDR_W] = '{default: '0};

  // Read-before-write port: the registered read holds until the next enabled access.
  always_ff @(posedge clk) begin
    if (en) begin
      rd_data <= mem[addr];
      if (wr_en) begin
        mem[addr] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: serves execute/memory-stage loads and stores against dmem_array.
// Latency: ack pulses RD_LAT (load) or WR_LAT (store) cycles after acceptance; next request one cycle after ack.
// Backpressure: requester holds dmem_memEn until dmem_ack; inputs are ignored while busy. Parity: DMEM_PARITY_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_memEn,
  input  logic        dmem_memwrEn,
  input  logic [0:15] dmem_addr,
  input  logic [0:63] dmem_data_in,
  output logic [0:63] dmem_data_out,
  output logic        dmem_ack,
  output logic        dmem_busy,
  output logic        dmem_perr
);

`ifdef DMEM_PARITY_EN
  localparam int ARR_W = DATA_W + 8;
`else
  localparam int ARR_W = DATA_W;
`endif

  localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WR_LAT - 1);

  dmem_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             is_wr;

  logic             accept;
  logic [CNT_W-1:0] lat_m1;
  logic [DATA_W-1:0] wr_word_data;
  logic [ARR_W-1:0]  wr_word;
  logic [ARR_W-1:0]  rd_word;
  logic              load_resp;
  logic              addr_unused;

  // Upper request address bits are deliberately dropped (aliasing).
  assign addr_unused = ^dmem_addr;

  // The RAM is touched only on the acceptance edge, so a store is all-or-nothing.
  assign accept       = (state == IDLE) && dmem_memEn && !reset;
  assign lat_m1       = dmem_memwrEn ? WR_CNT : RD_CNT;
  assign wr_word_data = dmem_data_in;

`ifdef DMEM_PARITY_EN
  assign wr_word = {word_parity(wr_word_data), wr_word_data};
`else
  assign wr_word = wr_word_data;
`endif

  dmem_array #(
    .ADDR_W (ADDR_W),
    .WIDTH  (ARR_W)
  ) u_array (
    .clk     (clk),
    .en      (accept),
    .wr_en   (dmem_memwrEn),
    .addr    (dmem_addr[REQ_ADDR_W-ADDR_W:REQ_ADDR_W-1]),
    .wr_data (wr_word),
    .rd_data (rd_word)
  );

  // Request FSM: accept in IDLE, count down latency in WAIT, pulse ack in RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      is_wr     <= 1'b0;
      dmem_ack  <= 1'b0;
      dmem_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dmem_memEn) begin
            is_wr     <= dmem_memwrEn;
            dmem_busy <= 1'b1;
            if (lat_m1 == '0) begin
              state    <= RESP;
              cnt      <= '0;
              dmem_ack <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= lat_m1;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state    <= RESP;
            dmem_ack <= 1'b1;
          end
        end
        RESP: begin
          state     <= IDLE;
          dmem_ack  <= 1'b0;
          dmem_busy <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          dmem_ack  <= 1'b0;
          dmem_busy <= 1'b0;
        end
      endcase
    end
  end

  // ack is high exactly in RESP, so it gates the held read word onto the bus.
  assign load_resp     = dmem_ack && !is_wr;
  assign dmem_data_out = load_resp ? rd_word[DATA_W-1:0] : '0;

`ifdef DMEM_PARITY_EN
  assign dmem_perr = load_resp && (word_parity(rd_word[DATA_W-1:0]) != rd_word[ARR_W-1:DATA_W]);
`else
  assign dmem_perr = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed tests of dmem_responder with default parameters.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
// Parity corruption test is active when DMEM_PARITY_EN is defined.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dmem_memEn = 1'b0;
  logic        dmem_memwrEn = 1'b0;
  logic [0:15] dmem_addr = '0;
  logic [0:63] dmem_data_in = '0;
  logic [0:63] dmem_data_out;
  logic        dmem_ack;
  logic        dmem_busy;
  logic        dmem_perr;

  int passed = 0;
  int total  = 0;

  dmem_responder u_dut (
    .clk           (clk),
    .reset         (reset),
    .dmem_memEn    (dmem_memEn),
    .dmem_memwrEn  (dmem_memwrEn),
    .dmem_addr     (dmem_addr),
    .dmem_data_in  (dmem_data_in),
    .dmem_data_out (dmem_data_out),
    .dmem_ack      (dmem_ack),
    .dmem_busy     (dmem_busy),
    .dmem_perr     (dmem_perr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one request, hold it until ack, report edges-to-ack (0 on timeout), then return to IDLE.
  task automatic do_req(input logic wr, input logic [15:0] addr, input logic [63:0] data,
                        output int lat, output logic [63:0] rdata, output logic perr);
    lat   = 0;
    rdata = '0;
    perr  = 1'b0;
    dmem_memEn   = 1'b1;
    dmem_memwrEn = wr;
    dmem_addr    = addr;
    dmem_data_in = data;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (dmem_ack === 1'b1) begin
        lat   = n;
        rdata = dmem_data_out;
        perr  = dmem_perr;
        break;
      end
    end
    dmem_memEn = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++; if (dmem_ack !== 1'b0) $display("FAIL reset_ack got %b want 0", dmem_ack); else passed++;
    total++; if (dmem_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", dmem_busy); else passed++;
    total++; if (dmem_data_out !== 64'h0) $display("FAIL reset_data got %h want 0", dmem_data_out); else passed++;
    total++; if (dmem_perr !== 1'b0) $display("FAIL reset_perr got %b want 0", dmem_perr); else passed++;
  endtask

  task automatic test_store_load;
    int lat; logic [63:0] rd; logic pe;
    do_req(1'b1, 16'h0005, 64'hDEADBEEF_01234567, lat, rd, pe);
    total++; if (lat !== 1) $display("FAIL store_lat got %0d want 1", lat); else passed++;
    total++; if (rd !== 64'h0) $display("FAIL store_data_out got %h want 0", rd); else passed++;
    do_req(1'b0, 16'h0005, 64'h0, lat, rd, pe);
    total++; if (lat !== 2) $display("FAIL load_lat got %0d want 2", lat); else passed++;
    total++; if (rd !== 64'hDEADBEEF_01234567) $display("FAIL load_data got %h want deadbeef01234567", rd); else passed++;
    total++; if (pe !== 1'b0) $display("FAIL load_perr got %b want 0", pe); else passed++;
    total++; if (dmem_data_out !== 64'h0) $display("FAIL idle_data got %h want 0", dmem_data_out); else passed++;
    do_req(1'b0, 16'h00F0, 64'h0, lat, rd, pe);
    total++; if (rd !== 64'h0 || pe !== 1'b0) $display("FAIL uninit_load got %h/%b want 0/0", rd, pe); else passed++;
  endtask

  task automatic test_held_request;
    int lat; logic [63:0] rd; logic pe;
    logic [5:0] ackv;
    logic [63:0] d2, d5;
    do_req(1'b1, 16'h0003, 64'hA5A5_0000_1234_5678, lat, rd, pe);
    ackv = '0; d2 = '0; d5 = '0;
    dmem_memEn   = 1'b1;
    dmem_memwrEn = 1'b0;
    dmem_addr    = 16'h0003;
    for (int n = 1; n <= 6; n++) begin
      tick();
      ackv[n-1] = dmem_ack;
      if (n == 2) d2 = dmem_data_out;
      if (n == 5) d5 = dmem_data_out;
    end
    dmem_memEn = 1'b0;
    tick();
    total++; if (ackv !== 6'b010010) $display("FAIL held_ack_pattern got %b want 010010", ackv); else passed++;
    total++; if (d2 !== 64'hA5A5_0000_1234_5678) $display("FAIL held_data1 got %h want a5a5000012345678", d2); else passed++;
    total++; if (d5 !== 64'hA5A5_0000_1234_5678) $display("FAIL held_data2 got %h want a5a5000012345678", d5); else passed++;
  endtask

  task automatic test_ignored_change;
    int lat; logic [63:0] rd; logic pe;
    do_req(1'b1, 16'h0001, 64'h0000_0000_0000_AAAA, lat, rd, pe);
    do_req(1'b1, 16'h0002, 64'h0000_0000_0000_BBBB, lat, rd, pe);
    dmem_memEn   = 1'b1;
    dmem_memwrEn = 1'b0;
    dmem_addr    = 16'h0001;
    tick();
    dmem_addr    = 16'h0002;
    dmem_memwrEn = 1'b1;
    dmem_data_in = 64'hFFFF_FFFF_FFFF_FFFF;
    total++; if (dmem_busy !== 1'b1 || dmem_ack !== 1'b0) $display("FAIL chg_wait got busy=%b ack=%b want 1/0", dmem_busy, dmem_ack); else passed++;
    tick();
    total++; if (dmem_ack !== 1'b1 || dmem_data_out !== 64'hAAAA) $display("FAIL chg_data got ack=%b %h want 1/aaaa", dmem_ack, dmem_data_out); else passed++;
    dmem_memEn = 1'b0;
    tick();
    do_req(1'b0, 16'h0002, 64'h0, lat, rd, pe);
    total++; if (rd !== 64'hBBBB) $display("FAIL chg_no_write got %h want bbbb", rd); else passed++;
  endtask

  task automatic test_wrap;
    int lat; logic [63:0] rd; logic pe;
    do_req(1'b1, 16'h0101, 64'h1111, lat, rd, pe);
    do_req(1'b0, 16'h0001, 64'h0, lat, rd, pe);
    total++; if (rd !== 64'h1111) $display("FAIL wrap_low got %h want 1111", rd); else passed++;
    do_req(1'b0, 16'hFF01, 64'h0, lat, rd, pe);
    total++; if (rd !== 64'h1111) $display("FAIL wrap_high got %h want 1111", rd); else passed++;
  endtask

  task automatic test_reset_mid;
    int lat; logic [63:0] rd; logic pe;
    logic late_ack;
    do_req(1'b1, 16'h0004, 64'hC0FFEE00_00C0FFEE, lat, rd, pe);
    dmem_memEn   = 1'b1;
    dmem_memwrEn = 1'b0;
    dmem_addr    = 16'h0004;
    tick();
    total++; if (dmem_busy !== 1'b1) $display("FAIL mid_busy got %b want 1", dmem_busy); else passed++;
    reset      = 1'b1;
    dmem_memEn = 1'b0;
    tick();
    reset = 1'b0;
    total++; if (u_dut.state !== 2'b00) $display("FAIL mid_state got %b want 00", u_dut.state); else passed++;
    total++; if (dmem_ack !== 1'b0 || dmem_busy !== 1'b0) $display("FAIL mid_ctrl got ack=%b busy=%b want 0/0", dmem_ack, dmem_busy); else passed++;
    total++; if (dmem_data_out !== 64'h0) $display("FAIL mid_data got %h want 0", dmem_data_out); else passed++;
    late_ack = 1'b0;
    for (int n = 0; n < 4; n++) begin
      tick();
      late_ack = late_ack | dmem_ack;
    end
    total++; if (late_ack !== 1'b0) $display("FAIL mid_late_ack got %b want 0", late_ack); else passed++;
    do_req(1'b0, 16'h0004, 64'h0, lat, rd, pe);
    total++; if (lat !== 2 || rd !== 64'hC0FFEE00_00C0FFEE) $display("FAIL mid_reload got lat=%0d %h want 2/c0ffee0000c0ffee", lat, rd); else passed++;
  endtask

  task automatic test_parity;
    int lat; logic [63:0] rd; logic pe;
    do_req(1'b1, 16'h0007, 64'h0123_4567_89AB_CDEF, lat, rd, pe);
`ifdef DMEM_PARITY_EN
    u_dut.u_array.mem[7][9] = ~u_dut.u_array.mem[7][9];
    do_req(1'b0, 16'h0007, 64'h0, lat, rd, pe);
    total++; if (pe !== 1'b1) $display("FAIL par_perr got %b want 1", pe); else passed++;
    total++; if (rd !== 64'h0123_4567_89AB_CFEF) $display("FAIL par_data got %h want 0123456789abcfef", rd); else passed++;
    total++; if (dmem_perr !== 1'b0) $display("FAIL par_pulse got %b want 0", dmem_perr); else passed++;
`else
    do_req(1'b0, 16'h0007, 64'h0, lat, rd, pe);
    total++; if (pe !== 1'b0) $display("FAIL par_perr got %b want 0", pe); else passed++;
    total++; if (rd !== 64'h0123_4567_89AB_CDEF) $display("FAIL par_data got %h want 0123456789abcdef", rd); else passed++;
`endif
    do_req(1'b0, 16'h0005, 64'h0, lat, rd, pe);
    total++; if (pe !== 1'b0) $display("FAIL par_clean got %b want 0", pe); else passed++;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_held_request();
    test_ignored_change();
    test_wrap();
    test_reset_mid();
    test_parity();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the CPU's execute/memory stage; serves the load/store requests that stage issues.
- Accepts a request (enable, write flag, 16-bit address, 64-bit store data), commits stores, and returns load data after a fixed latency.
- Signals completion with a one-cycle ack, so the requesting stage can hold its request and release its stall on ack.
- Sits between the execute/memory stage and the data RAM array.

Parameters:
- ADDR_W, 8, word-address bits used from the 16-bit request address (low ADDR_W bits; upper bits ignored); depth = 2**ADDR_W words.
- RD_LAT, 2, cycles from request acceptance to the read-data ack (legal range 1..7).
- WR_LAT, 1, cycles from request acceptance to the write ack (legal range 1..7).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- dmem_memEn  in  1  request valid; requester holds it high until ack.
- dmem_memwrEn  in  1  1 = store, 0 = load; sampled at acceptance.
- dmem_addr  in  [0:15]  word address; bit 15 is the LSB.
- dmem_data_in  in  [0:63]  store data; bit 0 is the MSB.
- dmem_data_out  out  [0:63]  load data; valid only in the cycle dmem_ack is high.
- dmem_ack  out  1  one-cycle completion pulse.
- dmem_busy  out  1  high while a request is in flight (state other than IDLE).
- dmem_perr  out  1  read parity error flag; see Optional Feature.

Behaviour:
- Reset (synchronous, active-high): next edge forces state=IDLE, counter=0, dmem_ack=0, dmem_busy=0, dmem_data_out=0, dmem_perr=0. RAM contents are not cleared.
- Reset asserted mid-operation aborts the transaction. A store is never half-written: the write commits only on the acceptance edge, so it has either fully happened or not at all.
- State machine IDLE, WAIT, RESP:
  - IDLE -> WAIT on an edge with dmem_memEn=1. Capture address, write flag and data; a store writes the RAM on this same edge. Load counter with lat-1, where lat = RD_LAT for a load or WR_LAT for a store.
  - IDLE -> RESP directly when lat-1 == 0.
  - WAIT: counter decrements each cycle; -> RESP when counter reaches 0.
  - RESP: dmem_ack=1 for exactly one cycle. For a load, dmem_data_out = RAM[captured addr] read at the acceptance edge. Then -> IDLE.
- Load latency: dmem_ack rises exactly lat cycles after the acceptance edge (lat=RD_LAT for loads, WR_LAT for stores). The default RD_LAT=2 gives a 2-cycle requester stall.
- In IDLE, dmem_memEn=1 on the edge immediately after the ack cycle is a new request (the pipeline advanced on the ack edge). Back-to-back throughput is therefore one request per lat+1 cycles.
- Request inputs are ignored in WAIT and RESP. A change in dmem_memwrEn, dmem_addr or dmem_data_in after acceptance has no effect.
- Outputs:
  - dmem_data_out returns to 0 outside RESP.
  - For a store, dmem_data_out = 0 during RESP.
  - dmem_busy = (state != IDLE).
- Address wrap: the address is truncated to its low ADDR_W bits, so 0x0100 aliases 0x0000 when ADDR_W=8.
- Read-after-write: a load accepted in the cycle after a store ack returns the new data; no bypass is needed.

Optional Feature:
- Macro DMEM_PARITY_EN.
- Defined:
  - The array stores 8 even-parity bits per word, one per byte [0:7]..[56:63], computed on write.
  - On a load RESP, dmem_perr=1 if any stored parity mismatches the recomputed parity. dmem_perr is a one-cycle pulse aligned with dmem_ack.
  - Data is returned unmodified.
  - A store or an uninitialised word never raises dmem_perr; the array initialises data and parity to 0.
- Undefined: no parity storage; dmem_perr is tied to 0.

Decomposition:
- Package dmem_pkg holds:
  - the state encoding IDLE=2'b00, WAIT=2'b01, RESP=2'b10;
  - the data width constant 64;
  - the request address width constant 16;
  - the latency counter width 3;
  - the parity function (XOR of a byte).
- Sub-module dmem_array: single-port synchronous RAM, 2**ADDR_W x 64 bits (x72 with DMEM_PARITY_EN), write enable plus registered read. The responder FSM wraps it.

Test Plan:
- Reset mid-read: load accepted, reset asserted during WAIT -> next cycle state=IDLE, dmem_ack=0, dmem_busy=0, dmem_data_out=0.
- Store then load: store 0xDEADBEEF_01234567 to addr 0x0005, then load 0x0005 -> store ack 1 cycle after acceptance; load ack exactly 2 cycles after acceptance with dmem_data_out=0xDEADBEEF_01234567, dmem_perr=0.
- Held request: keep dmem_memEn=1 with addr 0x0003 across the ack -> one ack, then a second independent transaction is accepted on the edge after the ack (acks at cycles 2 and 5 from the first acceptance).
- Ignored input change: change dmem_addr from 0x0001 to 0x0002 during WAIT -> data from 0x0001 returned.
- Wrap: store 0x1111 to 0x0101, load 0x0001 (ADDR_W=8) -> returns 0x1111.
- DMEM_PARITY_EN: corrupt bit 9 of array word 0x0007 by backdoor, then load 0x0007 -> dmem_perr=1 in the ack cycle and the corrupted data is returned; without the macro dmem_perr stays 0.
